// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer driving one external full-adder cell, LSB first.
// Holds the ripple carry in a flip-flop and assembles the sum in a shift register.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The cell only sees live operand bits while running; it is held at zero otherwise.
  assign fa_a  = (state == RUN) & a_sh[0];
  assign fa_b  = (state == RUN) & b_sh[0];
  assign fa_ci = (state == RUN) & carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          carry <= fa_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          // On the MSB cycle the carry register still holds the carry into the MSB.
          if (last_bit) begin
            sum   <= {fa_s, s_sh[WIDTH-1:1]};
            cout  <= fa_co;
            ovf   <= carry ^ fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 8-bit directed vectors plus an exhaustive
// 4-bit sweep, each instance wired to a behavioural full-adder cell.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       fa_a8, fa_b8, fa_ci8, fa_s8, fa_co8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       fa_a4, fa_b4, fa_ci4, fa_s4, fa_co4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int checks;
  int failures;
  int latency;
  int busy_cycles;
  int extra_dones;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_ci(fa_ci8), .fa_s(fa_s8), .fa_co(fa_co8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_ci(fa_ci4), .fa_s(fa_s4), .fa_co(fa_co4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Behavioural FA_HA cells
  assign fa_s8  = fa_a8 ^ fa_b8 ^ fa_ci8;
  assign fa_co8 = (fa_a8 & fa_b8) | (fa_a8 & fa_ci8) | (fa_b8 & fa_ci8);
  assign fa_s4  = fa_a4 ^ fa_b4 ^ fa_ci4;
  assign fa_co4 = (fa_a4 & fa_b4) | (fa_a4 & fa_ci4) | (fa_b4 & fa_ci4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One 8-bit add; optional stray start pulse during RUN cycle extra_start.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                               input int extra_start);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; cin8 = ~cv;
    latency = -1;
    busy_cycles = 0;
    if (busy8) busy_cycles++;
    for (int i = 1; i <= 20; i++) begin
      start8 = (i == extra_start);
      @(posedge clk);
      #1;
      if (busy8) busy_cycles++;
      if (done8) begin
        latency = i;
        break;
      end
    end
    start8 = 1'b0;
  endtask

  // Count done pulses over n cycles; leaves the DUT back in IDLE.
  task automatic waitQuiet(input int n);
    extra_dones = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done8) extra_dones++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_done", done8, 0);
    checkOutput("rst_sum", sum8, 0);
    checkOutput("rst_cout_ovf", {cout8, ovf8}, 0);
    checkOutput("rst_fa", {fa_a8, fa_b8, fa_ci8}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] test 1: 0x5A + 0x3C");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 0);
    checkOutput("t1_latency", latency, 8);
    checkOutput("t1_sum", sum8, 8'h96);
    checkOutput("t1_cout_ovf", {cout8, ovf8}, 2'b01);
    checkOutput("t1_fa_in_done", {fa_a8, fa_b8, fa_ci8}, 0);
    @(posedge clk);
    #1;
    checkOutput("t1_done_pulse", done8, 0);
    checkOutput("t1_sum_hold", sum8, 8'h96);
    waitQuiet(2);

    $display("[TB] test 2: 0xFF + 0x01");
    applyStimulus(8'hFF, 8'h01, 1'b0, 0);
    checkOutput("t2_latency", latency, 8);
    checkOutput("t2_busy_cycles", busy_cycles, 8);
    checkOutput("t2_sum", sum8, 8'h00);
    checkOutput("t2_cout_ovf", {cout8, ovf8}, 2'b10);
    waitQuiet(3);

    $display("[TB] test 3: 0xFF + 0xFF + 1, 0x7F + 0x01");
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
    checkOutput("t3a_sum", sum8, 8'hFF);
    checkOutput("t3a_cout_ovf", {cout8, ovf8}, 2'b10);
    waitQuiet(3);
    applyStimulus(8'h7F, 8'h01, 1'b0, 0);
    checkOutput("t3b_sum", sum8, 8'h80);
    checkOutput("t3b_cout_ovf", {cout8, ovf8}, 2'b01);
    waitQuiet(3);

    $display("[TB] test 4: 0x80 + 0x80 with stray start in RUN");
    applyStimulus(8'h80, 8'h80, 1'b0, 3);
    checkOutput("t4_latency", latency, 8);
    checkOutput("t4_sum", sum8, 8'h00);
    checkOutput("t4_cout_ovf", {cout8, ovf8}, 2'b11);
    waitQuiet(12);
    checkOutput("t4_single_done", extra_dones, 0);
    checkOutput("t4_idle_busy", busy8, 0);

    $display("[TB] test 5: reset in RUN cycle 4");
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t5_busy_run", busy8, 1);
    checkOutput("t5_fa_bit3", {fa_a8, fa_b8, fa_ci8}, 3'b110);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_busy_rst", busy8, 0);
    checkOutput("t5_fa_rst", {fa_a8, fa_b8, fa_ci8}, 0);
    checkOutput("t5_sum_rst", sum8, 0);
    checkOutput("t5_cout_ovf_rst", {cout8, ovf8}, 0);
    @(negedge clk);
    rst = 1'b0;
    waitQuiet(12);
    checkOutput("t5_no_done", extra_dones, 0);
    applyStimulus(8'h01, 8'h02, 1'b0, 0);
    checkOutput("t5_sum_after", sum8, 8'h03);
    checkOutput("t5_cout_ovf_after", {cout8, ovf8}, 0);

    $display("[TB] test 6: exhaustive WIDTH=4");
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          int ref_sum;
          int s_signed;
          logic got_done;
          logic exp_ovf;
          ref_sum = av + bv + cv;
          s_signed = ((av >= 8) ? av - 16 : av) + ((bv >= 8) ? bv - 16 : bv) + cv;
          exp_ovf = (s_signed > 7) || (s_signed < -8);
          @(negedge clk);
          a4 = 4'(av); b4 = 4'(bv); cin4 = cv[0]; start4 = 1'b1;
          @(posedge clk);
          #1;
          start4 = 1'b0;
          got_done = 1'b0;
          for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done4) begin
              got_done = 1'b1;
              break;
            end
          end
          checkOutput($sformatf("ex_done_%0d_%0d_%0d", av, bv, cv), got_done, 1);
          checkOutput($sformatf("ex_sum_%0d_%0d_%0d", av, bv, cv), {cout4, sum4}, ref_sum);
          checkOutput($sformatf("ex_ovf_%0d_%0d_%0d", av, bv, cv), ovf4, exp_ovf);
          @(posedge clk);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
